jtag_cmd_sequencer: RTL and testbench

//  Turns the raw bit stream from the virtual-JTAG capture path into command frames and executes them.

---
 rtl/jtag_cmd_pkg.sv | 36 +++
 rtl/jtag_bit_deser.sv | 40 ++++
 rtl/jtag_cmd_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_jtag_cmd_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_cmd_pkg.sv
// Shared constants and types for the JTAG command sequencer.
package jtag_cmd_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OPCODE  = 2'd1;
  localparam logic [1:0] ERR_LENGTH  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_EXEC,
    S_WAIT_RD,
    S_RESP,
    S_ERR
  } state_t;

  // Number of bytes a complete frame must carry for a given opcode.
  function automatic logic [2:0] req_len(input logic [7:0] op, input int data_bytes);
    case (op)
      OP_NOP:   return 3'd1;
      OP_READ:  return 3'd2;
      OP_WRITE: return 3'(2 + data_bytes);
      default:  return 3'd0;
    endcase
  endfunction

  function automatic logic op_known(input logic [7:0] op);
    return op <= OP_READ;
  endfunction

endpackage

// File: rtl/jtag_bit_deser.sv
// LSB-first bit-to-byte deserialiser. The completed byte is presented
// combinationally in the cycle of its 8th bit so the caller can act on it
// in the same cycle.
module jtag_bit_deser (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       partial
);

  logic [2:0] bit_cnt;
  logic [6:0] shift_q;
  logic       accept;

  assign accept     = bit_valid & en & ~clear;
  assign byte_valid = accept && (bit_cnt == 3'd7);
  assign byte_data  = {bit_data, shift_q};
  // Partial reflects the bit count after this cycle's bit is taken.
  assign partial    = accept ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0);

  // Shift new bits in at the top so the first bit ends up at bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
      shift_q <= 7'd0;
    end else if (clear) begin
      bit_cnt <= 3'd0;
      shift_q <= 7'd0;
    end else if (accept) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift_q <= {bit_data, shift_q[6:1]};
    end
  end

endmodule

// File: rtl/jtag_cmd_sequencer.sv
// Frames the captured JTAG bit stream into commands and runs them on the
// config register bus, returning read data as a byte stream.
//
// state     | meaning
// IDLE      | no frame in progress
// COLLECT   | receiving frame bytes
// EXEC      | bus request held until cfg_ready
// WAIT_RD   | waiting for cfg_rvalid
// RESP      | streaming read bytes out, byte0 first
// ERR       | one-cycle error strobe, then IDLE
module jtag_cmd_sequencer
  import jtag_cmd_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_BYTES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bit_valid,
  input  logic                    bit_data,
  input  logic                    frame_end,
  output logic                    cfg_valid,
  input  logic                    cfg_ready,
  output logic                    cfg_we,
  output logic [ADDR_W-1:0]       cfg_addr,
  output logic [8*DATA_BYTES-1:0] cfg_wdata,
  input  logic                    cfg_rvalid,
  input  logic [8*DATA_BYTES-1:0] cfg_rdata,
  output logic                    resp_valid,
  output logic [7:0]              resp_data,
  input  logic                    resp_ready,
  output logic                    busy,
  output logic                    err_pulse,
  output logic [1:0]              err_code
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  state_t        state;
  logic [2:0]    byte_cnt;
  logic [7:0]    opcode;
  logic [TW-1:0] tmr;
  logic [DW-1:0] rbuf;
  logic [2:0]    resp_left;

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          partial;
  logic          overrun;

  logic [7:0]    op_eff;
  logic [2:0]    cnt_eff;
  logic [2:0]    len_eff;
  logic          byte_err;

  jtag_bit_deser u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         ((state == S_IDLE) || (state == S_COLLECT)),
    .clear      (state == S_ERR),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .partial    (partial)
  );

  assign busy    = (state != S_IDLE);
  assign overrun = bit_valid | frame_end;

  // Frame view including any byte completing this cycle, so a frame_end
  // coinciding with the last bit is judged on the full frame.
  always_comb begin
    op_eff   = (byte_valid && byte_cnt == 3'd0) ? byte_data : opcode;
    cnt_eff  = byte_cnt + {2'b00, byte_valid};
    len_eff  = req_len(op_eff, DATA_BYTES);
    byte_err = 1'b0;
    if (byte_valid) begin
      if (byte_cnt == 3'd0) byte_err = !op_known(byte_data);
      else                  byte_err = (byte_cnt >= req_len(opcode, DATA_BYTES));
    end
  end

  // Main sequencer: frame collection, bus transaction, response, errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      byte_cnt   <= 3'd0;
      opcode     <= 8'd0;
      tmr        <= '0;
      rbuf       <= '0;
      resp_left  <= 3'd0;
      cfg_valid  <= 1'b0;
      cfg_we     <= 1'b0;
      cfg_addr   <= '0;
      cfg_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_data  <= 8'd0;
      err_pulse  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      err_pulse <= 1'b0;
      unique case (state)
        S_IDLE, S_COLLECT: begin
          if (byte_valid) begin
            byte_cnt <= cnt_eff;
            if (byte_cnt == 3'd0) opcode   <= byte_data;
            if (byte_cnt == 3'd1) cfg_addr <= byte_data[ADDR_W-1:0];
            for (int i = 0; i < DATA_BYTES; i++)
              if (byte_cnt == 3'(i + 2)) cfg_wdata[i*8 +: 8] <= byte_data;
          end
          if (byte_err) begin
            state     <= S_ERR;
            err_pulse <= 1'b1;
            err_code  <= (byte_cnt == 3'd0) ? ERR_OPCODE : ERR_LENGTH;
          end else if (frame_end && (state == S_COLLECT || bit_valid)) begin
            byte_cnt <= 3'd0;
            if (partial || cnt_eff < len_eff) begin
              state     <= S_ERR;
              err_pulse <= 1'b1;
              err_code  <= ERR_LENGTH;
            end else if (op_eff == OP_NOP) begin
              state <= S_IDLE;
            end else begin
              state     <= S_EXEC;
              cfg_valid <= 1'b1;
              cfg_we    <= (op_eff == OP_WRITE);
              tmr       <= TMR_LOAD;
            end
          end else if (bit_valid) begin
            state <= S_COLLECT;
          end
        end
        S_EXEC: begin
          if (overrun) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
          if (cfg_ready) begin
            cfg_valid <= 1'b0;
            if (cfg_we) begin
              state <= S_IDLE;
            end else begin
              state <= S_WAIT_RD;
              tmr   <= TMR_LOAD;
            end
          end else if (tmr == '0) begin
            cfg_valid <= 1'b0;
            state     <= S_ERR;
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_WAIT_RD: begin
          if (overrun) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
          if (cfg_rvalid) begin
            rbuf       <= cfg_rdata >> 8;
            resp_data  <= cfg_rdata[7:0];
            resp_valid <= 1'b1;
            resp_left  <= 3'(DATA_BYTES - 1);
            state      <= S_RESP;
          end else if (tmr == '0) begin
            state     <= S_ERR;
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_RESP: begin
          if (overrun) begin
            err_pulse <= 1'b1;
            err_code  <= ERR_TIMEOUT;
          end
          if (resp_ready) begin
            if (resp_left == 3'd0) begin
              resp_valid <= 1'b0;
              state      <= S_IDLE;
            end else begin
              resp_left <= resp_left - 3'd1;
              resp_data <= rbuf[7:0];
              rbuf      <= rbuf >> 8;
            end
          end
        end
        S_ERR: begin
          byte_cnt <= 3'd0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Directed bench for jtag_cmd_sequencer (ADDR_W=8, DATA_BYTES=2, TIMEOUT=1023).
module tb_jtag_cmd_sequencer;

  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_valid, bit_data, frame_end;
  logic        cfg_valid, cfg_ready, cfg_we;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_rvalid;
  logic [15:0] cfg_rdata;
  logic        resp_valid;
  logic [7:0]  resp_data;
  logic        resp_ready;
  logic        busy, err_pulse;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  jtag_cmd_sequencer #(.ADDR_W(8), .DATA_BYTES(2), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .frame_end  (frame_end),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_rvalid (cfg_rvalid),
    .cfg_rdata  (cfg_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy),
    .err_pulse  (err_pulse),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, input bit fe_last);
    for (int i = 0; i < n; i++) begin
      bit_valid = 1'b1;
      bit_data  = b[i];
      frame_end = fe_last && (i == n - 1);
      step();
    end
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fe_last);
    send_bits(b, 8, fe_last);
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    step();
    frame_end = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; frame_end = 1'b0;
    cfg_ready = 1'b0; cfg_rvalid = 1'b0; cfg_rdata = 16'h0; resp_ready = 1'b0;
    step(); step();
    chk("rst_cfg_valid", cfg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_err", {err_pulse, err_code}, 0);
    chk("rst_bus", {cfg_we, cfg_addr, cfg_wdata}, 0);
    rst_n = 1'b1;
    step();

    // 1: WRITE 01,10,34,12 with cfg_ready already high
    cfg_ready = 1'b1;
    send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    chk("w1_busy_collect", busy, 1);
    chk("w1_no_valid_early", cfg_valid, 0);
    pulse_fe();
    chk("w1_valid", cfg_valid, 1);
    chk("w1_bus", {cfg_we, cfg_addr, cfg_wdata}, {1'b1, 8'h10, 16'h1234});
    step();
    chk("w1_valid_one_cycle", cfg_valid, 0);
    chk("w1_busy_done", busy, 0);
    chk("w1_err_code", err_code, 0);
    cfg_ready = 1'b0;

    // 2: READ 02,05, late ready, rvalid in handshake cycle ignored
    send_byte(8'h02, 0); send_byte(8'h05, 0);
    pulse_fe();
    chk("r2_valid", cfg_valid, 1);
    chk("r2_bus", {cfg_we, cfg_addr}, {1'b0, 8'h05});
    step(); step();
    chk("r2_valid_held", {cfg_valid, cfg_we, cfg_addr}, {1'b1, 1'b0, 8'h05});
    cfg_ready = 1'b1; cfg_rvalid = 1'b1; cfg_rdata = 16'h1111;
    step();
    cfg_ready = 1'b0; cfg_rvalid = 1'b0;
    chk("r2_valid_dropped", cfg_valid, 0);
    chk("r2_hs_rvalid_ignored", resp_valid, 0);
    chk("r2_busy_wait", busy, 1);
    step();
    cfg_rvalid = 1'b1; cfg_rdata = 16'hBEEF;
    step();
    cfg_rvalid = 1'b0;
    chk("r2_byte0", {resp_valid, resp_data}, {1'b1, 8'hEF});
    for (int i = 0; i < 4; i++) begin
      step();
      chk("r2_stall_hold", {resp_valid, resp_data}, {1'b1, 8'hEF});
    end
    resp_ready = 1'b1;
    step();
    chk("r2_byte1", {resp_valid, resp_data}, {1'b1, 8'hBE});
    step();
    chk("r2_resp_done", {resp_valid, busy}, 0);
    resp_ready = 1'b0;

    // 3: bad opcode 0x7F, then a WRITE with frame_end on its last bit
    send_byte(8'h7F, 0);
    chk("o3_err_pulse", err_pulse, 1);
    chk("o3_err_code", err_code, 1);
    chk("o3_no_valid", cfg_valid, 0);
    step();
    chk("o3_pulse_one_cycle", {err_pulse, busy}, 0);
    pulse_fe();
    chk("o3_stray_fe_ignored", {busy, cfg_valid, err_pulse}, 0);
    send_byte(8'h01, 0); send_byte(8'h20, 0); send_byte(8'hCD, 0); send_byte(8'hAB, 1);
    chk("o3_next_valid", cfg_valid, 1);
    chk("o3_next_bus", {cfg_we, cfg_addr, cfg_wdata}, {1'b1, 8'h20, 16'hABCD});
    cfg_ready = 1'b1;
    step();
    cfg_ready = 1'b0;
    chk("o3_next_done", {cfg_valid, busy}, 0);
    chk("o3_code_sticky", err_code, 1);

    // 4b: WRITE with a fifth byte
    send_byte(8'h01, 0); send_byte(8'h10, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    chk("l4b_no_err_yet", {err_pulse, err_code}, {1'b0, 2'd1});
    send_byte(8'h55, 0);
    chk("l4b_err", {err_pulse, err_code, cfg_valid}, {1'b1, 2'd2, 1'b0});
    pulse_fe();
    step();
    chk("l4b_idle", {busy, cfg_valid, err_pulse}, 0);

    // 6: input during RESP is dropped, response intact
    cfg_ready = 1'b1;
    send_byte(8'h02, 0); send_byte(8'h05, 0);
    pulse_fe();
    chk("v6_valid", cfg_valid, 1);
    step();
    cfg_ready = 1'b0;
    cfg_rvalid = 1'b1; cfg_rdata = 16'h5AA5;
    step();
    cfg_rvalid = 1'b0;
    chk("v6_byte0", {resp_valid, resp_data}, {1'b1, 8'hA5});
    bit_valid = 1'b1; bit_data = 1'b1;
    step();
    bit_valid = 1'b0; bit_data = 1'b0;
    chk("v6_overrun", {err_pulse, err_code}, {1'b1, 2'd3});
    chk("v6_byte0_kept", {resp_valid, resp_data}, {1'b1, 8'hA5});
    step();
    chk("v6_pulse_end", err_pulse, 0);
    resp_ready = 1'b1;
    step();
    chk("v6_byte1", {resp_valid, resp_data}, {1'b1, 8'h5A});
    step();
    chk("v6_done", {resp_valid, busy}, 0);
    resp_ready = 1'b0;

    // 4a: READ frame truncated to 12 bits
    send_byte(8'h02, 0);
    send_bits(8'h05, 4, 0);
    chk("l4a_no_err_yet", {err_pulse, err_code}, {1'b0, 2'd3});
    pulse_fe();
    chk("l4a_err", {err_pulse, err_code, cfg_valid}, {1'b1, 2'd2, 1'b0});
    step();
    chk("l4a_idle", busy, 0);

    // 5: READ with no cfg_ready -> timeout
    send_byte(8'h02, 0); send_byte(8'h05, 0);
    pulse_fe();
    chk("t5_valid", cfg_valid, 1);
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    chk("t5_valid_last_cycle", {cfg_valid, err_pulse}, {1'b1, 1'b0});
    step();
    chk("t5_timeout", {cfg_valid, err_pulse, err_code}, {1'b0, 1'b1, 2'd3});
    step();
    chk("t5_idle", busy, 0);

    // 5: reset in the middle of EXEC
    send_byte(8'h02, 0); send_byte(8'h33, 0);
    pulse_fe();
    chk("t5_exec_again", {cfg_valid, cfg_addr}, {1'b1, 8'h33});
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cfg_valid", cfg_valid, 0);
    chk("t5_rst_outputs", {busy, resp_valid, err_pulse, err_code, cfg_addr, cfg_we}, 0);
    step();
    rst_n = 1'b1;
    step();

    // NOP with frame_end on the last bit
    send_byte(8'h00, 1);
    chk("nop_idle", {busy, cfg_valid, err_pulse, err_code}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
